cla_adder_pipe: RTL

//  Parametrised, pipelined carry-lookahead adder/subtractor for the execute datapath.

---
 rtl/cla_pkg.sv | 28 ++
 rtl/cla_group.sv | 65 ++++++
 rtl/cla_adder_pipe.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// -----------------------------------------------------------------------------
// cla_pkg
// Shared types and helpers for the pipelined carry-lookahead adder/subtractor.
//   cla_op_e       : operation encoding carried on in_op
//   CLA_GROUP_DEF  : default lookahead group width
//   cla_is_sub()   : operation inverts operand B
//   cla_uses_cin() : operation takes its carry-in from in_cin
// -----------------------------------------------------------------------------
package cla_pkg;

    typedef enum logic [1:0] {
        CLA_ADD = 2'b00,
        CLA_SUB = 2'b01,
        CLA_ADC = 2'b10,
        CLA_SBB = 2'b11
    } cla_op_e;

    localparam int CLA_GROUP_DEF = 4;

    function automatic logic cla_is_sub(input cla_op_e op);
        return (op == CLA_SUB) || (op == CLA_SBB);
    endfunction

    function automatic logic cla_uses_cin(input cla_op_e op);
        return (op == CLA_ADC) || (op == CLA_SBB);
    endfunction

endpackage

// File: rtl/cla_group.sv
// -----------------------------------------------------------------------------
// cla_group
// GROUP-bit carry-lookahead cell. Internal carries are fully expanded
// (no ripple), and the group propagate/generate pair is exported so the
// caller can build a second lookahead level across groups.
// Ports:
//   a, b  in  [GROUP-1:0]  operand bits (b already inverted for subtraction)
//   cin   in  1            carry into bit 0 of the group
//   sum   out [GROUP-1:0]  group sum bits
//   p     out 1            group propagate (all bits propagate)
//   g     out 1            group generate (carry leaves the group regardless of cin)
// -----------------------------------------------------------------------------
module cla_group
    import cla_pkg::*;
#(
    parameter int GROUP = CLA_GROUP_DEF
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             p,
    output logic             g
);

    logic [GROUP-1:0] bit_p;
    logic [GROUP-1:0] bit_g;
    logic [GROUP-1:0] carry;

    assign bit_p = a ^ b;
    assign bit_g = a & b;
    assign p     = &bit_p;

    // carry[i] = cin.P[0..i-1] + sum_j G[j].P[j+1..i-1]; group G is the
    // same expansion taken at i = GROUP without the cin term.
    always_comb begin
        logic acc;
        logic term;
        acc   = 1'b0;
        term  = 1'b0;
        carry = '0;
        g     = 1'b0;
        for (int i = 0; i <= GROUP; i++) begin
            acc = (i < GROUP) ? cin : 1'b0;
            for (int j = 0; j < i; j++) begin
                acc = acc & bit_p[j];
            end
            for (int j = 0; j < i; j++) begin
                term = bit_g[j];
                for (int k = j + 1; k < i; k++) begin
                    term = term & bit_p[k];
                end
                acc = acc | term;
            end
            if (i < GROUP) begin
                carry[i] = acc;
            end else begin
                g = acc;
            end
        end
    end

    assign sum = bit_p ^ carry;

endmodule

// File: rtl/cla_adder_pipe.sv
// -----------------------------------------------------------------------------
// cla_adder_pipe
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// The WIDTH-bit operands are cut into N = WIDTH/GROUP lookahead groups; stage k
// resolves the contiguous segment of N/STAGES groups starting at k*N/STAGES and
// registers the partial sum, the operand bits not yet consumed and the carry
// into the next segment. Latency is STAGES cycles, throughput one beat/cycle.
//
// Optional feature: define CLA_SATURATE_EN to add the in_sat port; a beat with
// in_sat=1 that overflows is clamped to signed max/min instead of wrapping.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_a, in_b  [WIDTH]   operands
//   in_op       [2]       cla_op_e: ADD, SUB, ADC, SBB
//   in_cin                carry/borrow-in (ADC/SBB only)
//   in_sat                saturate this beat (CLA_SATURATE_EN only)
//   out_valid / out_ready downstream handshake
//   out_sum     [WIDTH]   result
//   out_cout              carry out of the MSB (1 = no borrow for SUB/SBB)
//   out_ovf               signed overflow
//   out_zero              out_sum == 0
// -----------------------------------------------------------------------------
module cla_adder_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int GROUP  = CLA_GROUP_DEF,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
`ifdef CLA_SATURATE_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int N   = WIDTH / GROUP;
    localparam int GPS = N / STAGES;      // groups per stage
    localparam int SEG = GPS * GROUP;     // bits per stage

    genvar gi;
    genvar gj;

    logic [STAGES-1:0] v_reg;             // stage k holds a beat
    logic [STAGES-1:0] v_in;              // valid presented to stage k
    logic [STAGES-1:0] adv;               // stage k loads this cycle

    logic [WIDTH-1:0]  res_sum_reg;
    logic              res_cout_reg;
    logic              res_ovf_reg;

    // A stage may load when it or any stage downstream of it is empty, or the
    // consumer is taking the result: this is the unrolled form of
    // "empty or next stage advances", with no combinational chain.
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_ctl
            assign adv[gi] = out_ready | ~(&v_reg[STAGES-1:gi]);
            if (gi == 0) begin : g_vin
                assign v_in[gi] = in_valid;
            end else begin : g_vin
                assign v_in[gi] = v_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_reg <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    v_reg[s] <= v_in[s];
                end
            end
        end
    end

    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO = gi * SEG;       // first bit handled here
            localparam int HI = LO + SEG;       // first bit left for later

            logic [WIDTH-LO-1:0] a_src;         // operand bits [LO, WIDTH)
            logic [WIDTH-LO-1:0] b_src;
            logic                c_src;         // carry into bit LO
            logic [HI-1:0]       sum_comb;      // sum bits [0, HI)
            logic [SEG-1:0]      seg_sum;
            logic [GPS-1:0]      gp;
            logic [GPS-1:0]      gg;
            logic [GPS:0]        gc;            // carries into each group
            logic                ld;
`ifdef CLA_SATURATE_EN
            logic                sat_src;
`endif

            // Only load on a real beat so idle operands never disturb state.
            assign ld = adv[gi] & v_in[gi];

            if (gi == 0) begin : g_src
                assign a_src    = in_a;
                assign b_src    = cla_is_sub(cla_op_e'(in_op)) ? ~in_b : in_b;
                assign c_src    = cla_uses_cin(cla_op_e'(in_op)) ? in_cin
                                                                 : cla_is_sub(cla_op_e'(in_op));
                assign sum_comb = seg_sum;
`ifdef CLA_SATURATE_EN
                assign sat_src  = in_sat;
`endif
            end else begin : g_src
                assign a_src    = g_stage[gi-1].g_mid.a_reg;
                assign b_src    = g_stage[gi-1].g_mid.b_reg;
                assign c_src    = g_stage[gi-1].g_mid.c_reg;
                assign sum_comb = {seg_sum, g_stage[gi-1].g_mid.sum_reg};
`ifdef CLA_SATURATE_EN
                assign sat_src  = g_stage[gi-1].g_mid.sat_reg;
`endif
            end

            for (gj = 0; gj < GPS; gj++) begin : g_grp
                cla_group #(
                    .GROUP (GROUP)
                ) u_grp (
                    .a   (a_src[gj*GROUP +: GROUP]),
                    .b   (b_src[gj*GROUP +: GROUP]),
                    .cin (gc[gj]),
                    .sum (seg_sum[gj*GROUP +: GROUP]),
                    .p   (gp[gj]),
                    .g   (gg[gj])
                );
            end

            // Second-level lookahead across the groups of this segment.
            always_comb begin
                logic acc;
                logic term;
                acc  = 1'b0;
                term = 1'b0;
                gc   = '0;
                for (int j = 0; j <= GPS; j++) begin
                    acc = c_src;
                    for (int i = 0; i < j; i++) begin
                        acc = acc & gp[i];
                    end
                    for (int i = 0; i < j; i++) begin
                        term = gg[i];
                        for (int k = i + 1; k < j; k++) begin
                            term = term & gp[k];
                        end
                        acc = acc | term;
                    end
                    gc[j] = acc;
                end
            end

            if (gi < STAGES - 1) begin : g_mid
                logic [WIDTH-HI-1:0] a_reg;
                logic [WIDTH-HI-1:0] b_reg;
                logic [HI-1:0]       sum_reg;
                logic                c_reg;
`ifdef CLA_SATURATE_EN
                logic                sat_reg;
`endif
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        a_reg   <= '0;
                        b_reg   <= '0;
                        sum_reg <= '0;
                        c_reg   <= 1'b0;
`ifdef CLA_SATURATE_EN
                        sat_reg <= 1'b0;
`endif
                    end else if (ld) begin
                        a_reg   <= a_src[WIDTH-LO-1:SEG];
                        b_reg   <= b_src[WIDTH-LO-1:SEG];
                        sum_reg <= sum_comb;
                        c_reg   <= gc[GPS];
`ifdef CLA_SATURATE_EN
                        sat_reg <= sat_src;
`endif
                    end
                end
            end else begin : g_last
                logic             a_msb;
                logic             b_msb;
                logic             ovf;
                logic [WIDTH-1:0] sum_fin;

                // b_msb is the post-inversion operand, so one rule covers
                // both addition and subtraction.
                assign a_msb = a_src[WIDTH-LO-1];
                assign b_msb = b_src[WIDTH-LO-1];
                assign ovf   = (a_msb == b_msb) && (sum_comb[WIDTH-1] != a_msb);

`ifdef CLA_SATURATE_EN
                // Both operands non-negative means the true result ran past
                // signed max; both negative means it ran past signed min.
                assign sum_fin = (sat_src && ovf)
                               ? (a_msb ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}})
                               : sum_comb;
`else
                assign sum_fin = sum_comb;
`endif

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        res_sum_reg  <= '0;
                        res_cout_reg <= 1'b0;
                        res_ovf_reg  <= 1'b0;
                    end else if (ld) begin
                        res_sum_reg  <= sum_fin;
                        res_cout_reg <= gc[GPS];
                        res_ovf_reg  <= ovf;
                    end
                end
            end
        end
    endgenerate

    assign in_ready  = adv[0];
    assign out_valid = v_reg[STAGES-1];
    assign out_sum   = res_sum_reg;
    assign out_cout  = res_cout_reg;
    assign out_ovf   = res_ovf_reg;
    assign out_zero  = (res_sum_reg == '0);

endmodule
